rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter_pkg.sv | 12 +
 rtl/rf_wb_arbiter_scoreboard.sv | 33 +++
 rtl/rf_wb_arbiter.sv | 76 +++++++
 tb/tb_rf_wb_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// cpuDefine: shared CPU widths and writeback-arbiter defaults.
// Contents:
//   Gr               - register index width
//   DType            - datapath width
//   rfNum            - number of architectural registers
//   STARVE_LIMIT_DEF - default cap on consecutive lost arbitrations for long ops
package cpuDefine;
   localparam int Gr               = 5;
   localparam int DType            = 32;
   localparam int rfNum            = 32;
   localparam int STARVE_LIMIT_DEF = 4;
endpackage

// File: rtl/rf_wb_arbiter_scoreboard.sv
// rf_scoreboard: busy-register scoreboard for in-flight long ops plus decode hazard check.
// Ports:
//   aclk, reset           - clock, synchronous active-high reset
//   set_valid, set_rd     - long op dispatched; marks set_rd busy at the next edge
//   clr_valid, clr_rd     - long-op result accepted; clears clr_rd at the next edge
//   src_rj/src_rk/src_rd  - decode operands to check
//   hazard_stall          - some operand is busy in the current vector
module rf_scoreboard
   import cpuDefine::*;
(
   input  logic          aclk,
   input  logic          reset,
   input  logic          set_valid,
   input  logic [Gr-1:0] set_rd,
   input  logic          clr_valid,
   input  logic [Gr-1:0] clr_rd,
   input  logic [Gr-1:0] src_rj,
   input  logic [Gr-1:0] src_rk,
   input  logic [Gr-1:0] src_rd,
   output logic          hazard_stall
);
   logic [rfNum-1:0] busy, set_mask, clr_mask;
   always_comb begin
      set_mask     = set_valid ? rfNum'(1) << set_rd : '0;
      clr_mask     = clr_valid ? rfNum'(1) << clr_rd : '0;
      hazard_stall = ~reset & (busy[src_rj] | busy[src_rk] | busy[src_rd]);
   end
   // Set is OR-ed after the clear so a same-cycle set wins; bit 0 is forced low.
   always_ff @(posedge aclk) begin
      if (reset) busy <= '0;
      else       busy <= ((busy & ~clr_mask) | set_mask) & ~rfNum'(1);
   end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: register-file writeback arbiter between pipeline and long-op results.
// Ports:
//   aclk, reset                               - clock, synchronous active-high reset
//   pipe_wb_valid/rd/data, pipe_wb_ready      - pipeline writeback request (default priority)
//   lop_valid/rd/data, lop_ready              - long-op result request (anti-starvation)
//   issue_lop_valid, issue_lop_rd             - long-op dispatch, marks rd busy
//   src_rj, src_rk, src_rd, hazard_stall      - decode operand busy check
//   regWriteEn, rd_wb_out, regWriteData       - registered regfile write port
module rf_wb_arbiter
   import cpuDefine::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic             aclk,
   input  logic             reset,
   input  logic             pipe_wb_valid,
   input  logic [Gr-1:0]    pipe_wb_rd,
   input  logic [DType-1:0] pipe_wb_data,
   output logic             pipe_wb_ready,
   input  logic             lop_valid,
   input  logic [Gr-1:0]    lop_rd,
   input  logic [DType-1:0] lop_data,
   output logic             lop_ready,
   input  logic             issue_lop_valid,
   input  logic [Gr-1:0]    issue_lop_rd,
   input  logic [Gr-1:0]    src_rj,
   input  logic [Gr-1:0]    src_rk,
   input  logic [Gr-1:0]    src_rd,
   output logic             hazard_stall,
   output logic             regWriteEn,
   output logic [Gr-1:0]    rd_wb_out,
   output logic [DType-1:0] regWriteData
);
   localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   logic [SW-1:0] starve_cnt;
   logic          at_limit, lop_win;
   always_comb begin
      at_limit      = starve_cnt == SW'(STARVE_LIMIT);
      lop_win       = lop_valid & (~pipe_wb_valid | at_limit);
      pipe_wb_ready = ~reset & pipe_wb_valid & ~lop_win;
      lop_ready     = ~reset & lop_win;
   end
   // A waiting long op that is not granted can only mean it lost to the pipeline.
   always_ff @(posedge aclk) begin
      if (reset || !lop_valid || lop_ready) starve_cnt <= '0;
      else if (!at_limit)                   starve_cnt <= starve_cnt + SW'(1);
   end
   always_ff @(posedge aclk) begin
      if (reset) begin
         regWriteEn   <= 1'b0;
         rd_wb_out    <= '0;
         regWriteData <= '0;
      end else begin
         regWriteEn <= (pipe_wb_ready && pipe_wb_rd != '0) || (lop_ready && lop_rd != '0);
         if (pipe_wb_ready) begin
            rd_wb_out    <= pipe_wb_rd;
            regWriteData <= pipe_wb_data;
         end else if (lop_ready) begin
            rd_wb_out    <= lop_rd;
            regWriteData <= lop_data;
         end
      end
   end
   rf_scoreboard u_scoreboard (
      .aclk         (aclk),
      .reset        (reset),
      .set_valid    (issue_lop_valid),
      .set_rd       (issue_lop_rd),
      .clr_valid    (lop_valid & lop_ready),
      .clr_rd       (lop_rd),
      .src_rj       (src_rj),
      .src_rk       (src_rk),
      .src_rd       (src_rd),
      .hazard_stall (hazard_stall)
   );
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed and randomized checks of rf_wb_arbiter against a behavioural model.
module tb_rf_wb_arbiter;
   import cpuDefine::*;
   localparam int LIM = 4;
   logic             aclk = 1'b0, reset;
   logic             pipe_wb_valid, pipe_wb_ready, lop_valid, lop_ready;
   logic [Gr-1:0]    pipe_wb_rd, lop_rd, issue_lop_rd, src_rj, src_rk, src_rd, rd_wb_out;
   logic [DType-1:0] pipe_wb_data, lop_data, regWriteData;
   logic             issue_lop_valid, hazard_stall, regWriteEn;
   always #5 aclk = ~aclk;
   rf_wb_arbiter #(.STARVE_LIMIT(LIM)) dut (
      .aclk(aclk), .reset(reset),
      .pipe_wb_valid(pipe_wb_valid), .pipe_wb_rd(pipe_wb_rd), .pipe_wb_data(pipe_wb_data),
      .pipe_wb_ready(pipe_wb_ready),
      .lop_valid(lop_valid), .lop_rd(lop_rd), .lop_data(lop_data), .lop_ready(lop_ready),
      .issue_lop_valid(issue_lop_valid), .issue_lop_rd(issue_lop_rd),
      .src_rj(src_rj), .src_rk(src_rk), .src_rd(src_rd), .hazard_stall(hazard_stall),
      .regWriteEn(regWriteEn), .rd_wb_out(rd_wb_out), .regWriteData(regWriteData)
   );
   int n_vec = 0, n_err = 0;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   int          starve = 0;
   bit          busy [32];
   bit          e_en, e_full;
   bit [4:0]    e_rd;
   bit [31:0]   e_data;
   logic        o_pr, o_lr, o_hz;
   task automatic idle();
      {pipe_wb_valid, lop_valid, issue_lop_valid} = '0;
      {pipe_wb_rd, lop_rd, issue_lop_rd, src_rj, src_rk, src_rd} = '0;
      pipe_wb_data = '0;
      lop_data     = '0;
   endtask
   // One cycle: check combinational outputs against the model, advance model, check registers.
   task automatic step();
      bit pr, lr, hz, lw;
      #1;
      lw = lop_valid && (!pipe_wb_valid || starve >= LIM);
      pr = !reset && pipe_wb_valid && !lw;
      lr = !reset && lw;
      hz = !reset && (busy[src_rj] || busy[src_rk] || busy[src_rd]);
      o_pr = pipe_wb_ready; o_lr = lop_ready; o_hz = hazard_stall;
      chk("pipe_wb_ready", pipe_wb_ready, pr);
      chk("lop_ready", lop_ready, lr);
      chk("hazard_stall", hazard_stall, hz);
      if (reset) begin
         starve = 0;
         foreach (busy[i]) busy[i] = 0;
         e_en = 0; e_rd = 0; e_data = 0; e_full = 1;
      end else begin
         e_full = 0; e_en = 0;
         if (pr) begin e_en = pipe_wb_rd != 0; e_rd = pipe_wb_rd; e_data = pipe_wb_data; end
         else if (lr) begin e_en = lop_rd != 0; e_rd = lop_rd; e_data = lop_data; end
         starve = (!lop_valid || lr) ? 0 : (starve < LIM ? starve + 1 : LIM);
         if (lr) busy[lop_rd] = 0;
         if (issue_lop_valid && issue_lop_rd != 0) busy[issue_lop_rd] = 1;
      end
      @(posedge aclk); #1;
      chk("regWriteEn", regWriteEn, e_en);
      if (e_en || e_full) begin
         chk("rd_wb_out", rd_wb_out, e_rd);
         chk("regWriteData", regWriteData, e_data);
      end
   endtask
   initial begin
      bit [4:0] pat;
      idle();
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      // pipe-only write
      pipe_wb_valid = 1; pipe_wb_rd = 5; pipe_wb_data = 32'h1234;
      step();
      chk("pipe_only_en", regWriteEn, 1'b1);
      chk("pipe_only_rd", rd_wb_out, 5'd5);
      chk("pipe_only_data", regWriteData, 32'h1234);
      // continuous contention: pipe wins four times, then the long op
      pat = 5'b11110;
      lop_valid = 1; lop_rd = 0; lop_data = 32'hdead;
      for (int k = 0; k < 10; k++) begin
         pipe_wb_rd = 5'(k + 1); pipe_wb_data = 32'(k);
         step();
         chk("contention_pipe", o_pr, pat[4 - (k % 5)]);
      end
      idle();
      // busy register stalls decode until the cycle after its result is accepted
      issue_lop_valid = 1; issue_lop_rd = 7;
      step();
      idle(); src_rk = 7;
      step();
      chk("hazard_rd7_busy", o_hz, 1'b1);
      lop_valid = 1; lop_rd = 7; lop_data = 32'h77;
      step();
      chk("hazard_rd7_no_bypass", o_hz, 1'b1);
      chk("lop_rd7_accept", o_lr, 1'b1);
      lop_valid = 0;
      step();
      chk("hazard_rd7_clear", o_hz, 1'b0);
      // same-cycle set and clear: set wins
      idle(); issue_lop_valid = 1; issue_lop_rd = 9;
      step();
      lop_valid = 1; lop_rd = 9;
      step();
      idle(); src_rj = 9;
      step();
      chk("hazard_rd9_set_wins", o_hz, 1'b1);
      // register 0 never busy and never written
      idle(); issue_lop_valid = 1; issue_lop_rd = 0;
      step();
      idle();
      step();
      chk("hazard_rd0", o_hz, 1'b0);
      pipe_wb_valid = 1; pipe_wb_rd = 0; pipe_wb_data = 32'hffff;
      step();
      chk("rd0_no_write", regWriteEn, 1'b0);
      // reset with busy bits and a waiting long op
      idle(); issue_lop_valid = 1; issue_lop_rd = 3;
      step();
      idle(); pipe_wb_valid = 1; pipe_wb_rd = 4; lop_valid = 1; lop_rd = 3; src_rk = 3;
      reset = 1;
      step();
      chk("reset_no_pipe_ready", o_pr, 1'b0);
      chk("reset_no_lop_ready", o_lr, 1'b0);
      chk("reset_no_stall", o_hz, 1'b0);
      chk("reset_no_write", regWriteEn, 1'b0);
      reset = 0; pipe_wb_valid = 0; lop_valid = 0;
      step();
      chk("reset_busy_cleared", o_hz, 1'b0);
      // randomized traffic with held requests
      idle();
      o_pr = 0; o_lr = 0;
      for (int c = 0; c < 3000; c++) begin
         if (!pipe_wb_valid || o_pr) begin
            pipe_wb_valid = $urandom_range(0, 3) != 0;
            pipe_wb_rd    = 5'($urandom_range(0, 15));
            pipe_wb_data  = $urandom;
         end
         if (!lop_valid || o_lr) begin
            lop_valid = $urandom_range(0, 1) != 0;
            lop_rd    = 5'($urandom_range(0, 15));
            lop_data  = $urandom;
         end
         issue_lop_valid = $urandom_range(0, 3) == 0;
         issue_lop_rd    = 5'($urandom_range(0, 15));
         src_rj = 5'($urandom_range(0, 15));
         src_rk = 5'($urandom_range(0, 15));
         src_rd = 5'($urandom_range(0, 15));
         reset  = $urandom_range(0, 49) == 0;
         step();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
